// File: rtl/tim_apb_ctrl.sv
// APB slave transfer controller for the timer register bank: turns APB transfers into single-cycle rd_en/wr_en strobes.
// Optional byte-strobe support (tim_pstrb, read-modify-write on partial strobes) is enabled by TIM_APB_PSTRB_EN.
module tim_apb_ctrl #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [11:0] ADDR_MAX    = 12'h01C
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tim_psel,
  input  logic        tim_penable,
  input  logic        tim_pwrite,
  input  logic [11:0] tim_paddr,
  input  logic [31:0] tim_pwdata,
`ifdef TIM_APB_PSTRB_EN
  input  logic [3:0]  tim_pstrb,
`endif
  output logic        tim_pready,
  output logic        tim_pslverr,
  output logic [31:0] tim_prdata,
  output logic        rd_en,
  output logic        wr_en,
  output logic [11:0] reg_paddr,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Last counter value before DONE; unused when there are no wait states.
  localparam logic [3:0] CNT_LAST = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        ld;
  logic [11:0] paddr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic        err_q;
  logic        setup;
  logic        fire;
  logic        ok;
`ifdef TIM_APB_PSTRB_EN
  logic [3:0]  strb_q;
  logic        rmw;
  logic [31:0] merged;
`endif

  assign setup = tim_psel & ~tim_penable;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      paddr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef TIM_APB_PSTRB_EN
      strb_q  <= '0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (ld) begin
        paddr_q <= tim_paddr;
        wdata_q <= tim_pwdata;
        write_q <= tim_pwrite;
        err_q   <= (tim_paddr[1:0] != 2'b00) | (tim_paddr > ADDR_MAX);
`ifdef TIM_APB_PSTRB_EN
        strb_q  <= tim_pstrb;
`endif
      end
    end
  end

  // Access phase seen in IDLE (no preceding setup) is ignored.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ld      = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          ld      = 1'b1;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (!tim_psel)             state_d = IDLE;
        else if (cnt == CNT_LAST)  state_d = DONE;
        else                       cnt_d   = cnt + 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fire        = (state == DONE) & tim_psel & tim_penable & ~sys_rst;
    ok          = fire & ~err_q;
    tim_pready  = fire;
    tim_pslverr = fire & err_q;
    tim_prdata  = (ok & ~write_q) ? reg_rdata : 32'h0;
    reg_paddr   = sys_rst ? 12'h0 : paddr_q;
`ifdef TIM_APB_PSTRB_EN
    // Partial strobes merge unselected bytes from the current register value.
    rmw    = ok & write_q & ~(&strb_q) & (|strb_q);
    merged = '0;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = strb_q[i] ? wdata_q[8*i +: 8] : reg_rdata[8*i +: 8];
    rd_en     = (ok & ~write_q) | rmw;
    wr_en     = ok & write_q & (|strb_q);
    reg_wdata = sys_rst ? 32'h0 : (rmw ? merged : wdata_q);
`else
    rd_en     = ok & ~write_q;
    wr_en     = ok & write_q;
    reg_wdata = sys_rst ? 32'h0 : wdata_q;
`endif
  end

endmodule
